// File: rtl/aybus_pkg.sv
// Shared types and bus control codes for the AY-style parallel bus master.
package aybus_pkg;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_DATA = 2'b10,
    CMD_CFG     = 2'b11
  } aybus_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RECOV
  } aybus_state_e;

  // {aybdir, aybc2, aybc1}
  localparam logic [2:0] CTL_IDLE  = 3'b010;
  localparam logic [2:0] CTL_LATCH = 3'b111;
  localparam logic [2:0] CTL_WRITE = 3'b110;
  localparam logic [2:0] CTL_READ  = 3'b011;

  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  function automatic logic [2:0] strobe_ctl(aybus_cmd_e c);
    logic [2:0] r;
    r = CTL_LATCH;
    case (c)
      CMD_WR_DATA: r = CTL_WRITE;
      CMD_RD_DATA: r = CTL_READ;
      default:     r = CTL_LATCH;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aybus_master_if.sv
// Request/response and AY bus pins of the bus master, grouped for port use.
interface aybus_master_if;
  logic       req;
  logic [1:0] cmd;
  logic [7:0] wdata;
  logic       ready;
  logic       done;
  logic       err;
  logic [7:0] rdata;
  logic       aybdir;
  logic       aybc2;
  logic       aybc1;
  logic       aya8;
  logic       aya9_n;
  logic [7:0] ayd_o;
  logic       ayd_oe;
  logic [7:0] ayd_i;

  modport master (
    input  req, cmd, wdata, ayd_i,
    output ready, done, err, rdata,
    output aybdir, aybc2, aybc1, aya8, aya9_n, ayd_o, ayd_oe
  );

  modport slave (
    output req, cmd, wdata, ayd_i,
    input  ready, done, err, rdata,
    input  aybdir, aybc2, aybc1, aya8, aya9_n, ayd_o, ayd_oe
  );
endinterface

// File: rtl/aybus_timer.sv
// Phase down-counter: load a length, count to zero, flag the last clock of the phase.
module aybus_timer
  import aybus_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] len_i,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = len_i - CNT_ONE;
    else if (cnt_q != '0)
      cnt_d = cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/aybus_master.sv
// AY-style bus master sequencing setup/strobe/hold/recovery with registered pins.
// The cfg-port command (cmd=11) exists only when AYBUS_MASTER_CFGPORT_EN is defined.
//
// state  | meaning
// IDLE   | ready, bus parked, waiting for req
// SETUP  | chip selected, address/data settling
// STROBE | bus control code asserted
// HOLD   | strobe released, data still driven
// RECOV  | bus parked, enforcing idle gap
module aybus_master
  import aybus_pkg::*;
#(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 20,
  parameter int HOLD_CYC   = 2,
  parameter int RECOV_CYC  = 8
) (
  input logic            clk,
  input logic            rst_n,
  aybus_master_if.master bus
);

  if (SETUP_CYC < 1 || SETUP_CYC > 31 || STROBE_CYC < 1 || STROBE_CYC > 31 ||
      HOLD_CYC < 1 || HOLD_CYC > 31 || RECOV_CYC < 1 || RECOV_CYC > 31) begin : g_bad_param
    $error("aybus_master: phase lengths must be 1..31");
  end

  localparam logic [CNT_W-1:0] LEN_SETUP  = CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0] LEN_STROBE = CNT_W'(STROBE_CYC);
  localparam logic [CNT_W-1:0] LEN_HOLD   = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] LEN_RECOV  = CNT_W'(RECOV_CYC);

  aybus_state_e     state_q, state_d;
  aybus_cmd_e       cmd_q, cmd_d;
  logic [7:0]       data_q, data_d, wdata_in;
  logic             cmd_ok, accept, reject;
  logic             tmr_load, tmr_last;
  logic [CNT_W-1:0] tmr_len;
  logic [2:0]       ctl_q, ctl_d;
  logic             a8_q, a8_d, a9n_q, a9n_d, oe_q, oe_d;
  logic [7:0]       dout_q, dout_d, rdata_q, rdata_d;
  logic             ready_q, ready_d, done_q, done_d, err_q, err_d;

`ifdef AYBUS_MASTER_CFGPORT_EN
  assign cmd_ok   = 1'b1;
  assign wdata_in = (bus.cmd == CMD_CFG) ? {4'hF, bus.wdata[3:0]} : bus.wdata;
`else
  assign cmd_ok   = (bus.cmd != CMD_CFG);
  assign wdata_in = bus.wdata;
`endif

  assign accept = (state_q == ST_IDLE) && bus.req && cmd_ok;
  assign reject = (state_q == ST_IDLE) && bus.req && !cmd_ok;
  assign cmd_d  = accept ? aybus_cmd_e'(bus.cmd) : cmd_q;
  assign data_d = accept ? wdata_in : data_q;

  aybus_timer u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (tmr_load),
    .len_i  (tmr_len),
    .last_o (tmr_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_WR_ADDR;
      data_q  <= '0;
      ctl_q   <= CTL_IDLE;
      a8_q    <= 1'b0;
      a9n_q   <= 1'b1;
      oe_q    <= 1'b0;
      dout_q  <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      ctl_q   <= ctl_d;
      a8_q    <= a8_d;
      a9n_q   <= a9n_d;
      oe_q    <= oe_d;
      dout_q  <= dout_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_len  = LEN_SETUP;
    case (state_q)
      ST_IDLE:   if (accept)   begin state_d = ST_SETUP;  tmr_load = 1'b1; tmr_len = LEN_SETUP;  end
      ST_SETUP:  if (tmr_last) begin state_d = ST_STROBE; tmr_load = 1'b1; tmr_len = LEN_STROBE; end
      ST_STROBE: if (tmr_last) begin state_d = ST_HOLD;   tmr_load = 1'b1; tmr_len = LEN_HOLD;   end
      ST_HOLD:   if (tmr_last) begin state_d = ST_RECOV;  tmr_load = 1'b1; tmr_len = LEN_RECOV;  end
      ST_RECOV:  if (tmr_last) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Pins are computed from the next state so every output comes straight from a flop.
  always_comb begin
    ctl_d   = CTL_IDLE;
    a8_d    = 1'b0;
    a9n_d   = 1'b1;
    oe_d    = 1'b0;
    dout_d  = '0;
    if (state_d inside {ST_SETUP, ST_STROBE, ST_HOLD}) begin
      a8_d  = 1'b1;
      a9n_d = 1'b0;
      oe_d  = (cmd_d != CMD_RD_DATA);
      if (oe_d) dout_d = data_d;
      if (state_d == ST_STROBE) ctl_d = strobe_ctl(cmd_d);
    end
    ready_d = (state_d == ST_IDLE);
    done_d  = (state_q == ST_HOLD) && (state_d == ST_RECOV);
    err_d   = reject;
    rdata_d = rdata_q;
    if (state_q == ST_STROBE && tmr_last && cmd_q == CMD_RD_DATA)
      rdata_d = bus.ayd_i;
  end

  assign bus.ready  = ready_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.rdata  = rdata_q;
  assign bus.aybdir = ctl_q[2];
  assign bus.aybc2  = ctl_q[1];
  assign bus.aybc1  = ctl_q[0];
  assign bus.aya8   = a8_q;
  assign bus.aya9_n = a9n_q;
  assign bus.ayd_o  = dout_q;
  assign bus.ayd_oe = oe_q;

endmodule

// File: tb/tb_aybus_master.sv
// Bench for aybus_master: timeline model checked every cycle plus directed literal checks.
module tb_aybus_master;

  localparam int S = 2, T = 20, H = 2, R = 8;
  localparam int TOTAL = S + T + H + R;
`ifdef AYBUS_MASTER_CFGPORT_EN
  localparam bit CFG_EN = 1'b1;
`else
  localparam bit CFG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  aybus_master_if bus();

  aybus_master #(.SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H), .RECOV_CYC(R)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] exp_code(input logic [1:0] c);
    case (c)
      2'b01:   return 3'b110;
      2'b10:   return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  // Timeline model: m_n counts clocks since acceptance.
  logic       m_busy = 1'b0;
  int         m_n = 0;
  logic [1:0] m_cmd = 2'b00;
  logic [7:0] m_data = 8'h00;
  logic [7:0] m_rdata = 8'h00;
  logic       m_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_n     <= 0;
      m_rdata <= 8'h00;
      m_err   <= 1'b0;
    end else begin
      m_err <= 1'b0;
      if (m_busy) begin
        if (m_cmd == 2'b10 && m_n == S + T - 1) m_rdata <= bus.ayd_i;
        m_n <= m_n + 1;
        if (m_n + 1 == TOTAL) m_busy <= 1'b0;
      end else if (bus.req) begin
        if (bus.cmd == 2'b11 && !CFG_EN) m_err <= 1'b1;
        else begin
          m_busy <= 1'b1;
          m_n    <= 0;
          m_cmd  <= bus.cmd;
          m_data <= (bus.cmd == 2'b11) ? {4'hF, bus.wdata[3:0]} : bus.wdata;
        end
      end
    end
  end

  logic        e_sel, e_oe;
  logic [2:0]  e_ctl;
  logic [15:0] e_vec, a_vec;

  always @(negedge clk) begin
    e_sel = m_busy && (m_n < S + T + H);
    e_oe  = e_sel && (m_cmd != 2'b10);
    e_ctl = (e_sel && m_n >= S && m_n < S + T) ? exp_code(m_cmd) : 3'b010;
    e_vec = {!m_busy, m_busy && (m_n == S + T + H), m_err, e_ctl, e_sel, !e_sel, e_oe, 7'b0};
    a_vec = {bus.ready, bus.done, bus.err, bus.aybdir, bus.aybc2, bus.aybc1,
             bus.aya8, bus.aya9_n, bus.ayd_oe, 7'b0};
    chk("cycle_ctrl", a_vec, e_vec);
    chk("cycle_rdata", bus.rdata, m_rdata);
    if (!rst_n)    chk("reset_ayd_o", bus.ayd_o, 8'h00);
    else if (e_oe) chk("cycle_ayd_o", bus.ayd_o, m_data);
  end

  // Bus decoder on the far side of the pins.
  logic [7:0] dec_addr = 8'h00;
  logic [7:0] dec_reg [16];
  logic       dec_prev_wr = 1'b0;
  int         dec_wr_cnt = 0;

  always @(posedge clk) begin
    dec_prev_wr <= 1'b0;
    if (bus.aya8 && !bus.aya9_n) begin
      if ({bus.aybdir, bus.aybc2, bus.aybc1} == 3'b111) dec_addr <= bus.ayd_o;
      if ({bus.aybdir, bus.aybc2, bus.aybc1} == 3'b110) begin
        dec_prev_wr <= 1'b1;
        if (!dec_prev_wr) begin
          dec_reg[dec_addr[3:0]] <= bus.ayd_o;
          dec_wr_cnt <= dec_wr_cnt + 1;
        end
      end
    end
  end

  int t_done, t_ready, n_strobe, n_addr, n_oe, n_done;
  logic [2:0] s_code;
  logic [7:0] s_dout;

  task automatic run(input logic [1:0] c, input logic [7:0] d, input bit hold);
    logic [2:0] ctl;
    bus.req = 1'b1; bus.cmd = c; bus.wdata = d; bus.ayd_i = 8'hA5;
    t_done = -1; t_ready = -1; n_strobe = 0; n_addr = 0; n_oe = 0; n_done = 0;
    s_code = 3'b000; s_dout = 8'h00;
    @(negedge clk);
    for (int i = 0; i <= 60; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 0 && !hold) bus.req = 1'b0;
      bus.ayd_i = (i == S + T - 1) ? 8'h5A : 8'hA5;
      ctl = {bus.aybdir, bus.aybc2, bus.aybc1};
      if (bus.aya8 && ctl == 3'b010) n_addr++;
      if (bus.aya8 && ctl != 3'b010) begin n_strobe++; s_code = ctl; s_dout = bus.ayd_o; end
      if (bus.ayd_oe) n_oe++;
      if (bus.done) begin n_done++; if (t_done < 0) t_done = i; end
      if (bus.ready) begin t_ready = i; break; end
    end
    if (t_ready < 0) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n_err, n_busy, n_act;
    bus.req = 1'b0; bus.cmd = 2'b00; bus.wdata = 8'h00; bus.ayd_i = 8'hA5;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.ready, 1'b1);
    chk("rst_ctl", {bus.aybdir, bus.aybc2, bus.aybc1, bus.aya8, bus.aya9_n, bus.ayd_oe}, 6'b010010);
    chk("rst_rdata", bus.rdata, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    run(2'b00, 8'h07, 1'b0);
    chk("wa_done_lat", t_done, 24);
    chk("wa_ready_lat", t_ready, 32);
    chk("wa_strobe_len", n_strobe, 20);
    chk("wa_addr_phase", n_addr, 4);
    chk("wa_code", s_code, 3'b111);
    chk("wa_dout", s_dout, 8'h07);

    run(2'b10, 8'h00, 1'b0);
    chk("rd_rdata", bus.rdata, 8'h5A);
    chk("rd_oe_count", n_oe, 0);
    chk("rd_code", s_code, 3'b011);

    run(2'b01, 8'hC3, 1'b1);
    chk("wd_strobe_len", n_strobe, 20);
    chk("wd_done_cnt", n_done, 1);
    chk("wd_code", s_code, 3'b110);
    chk("wd_ready_lat", t_ready, 32);
    chk("dec_addr", dec_addr, 8'h07);
    chk("dec_reg7", dec_reg[7], 8'hC3);
    chk("dec_wr_cnt", dec_wr_cnt, 1);
    run(2'b00, 8'h0E, 1'b0);
    chk("held_req_ready_lat", t_ready, 32);
    chk("rd_rdata_kept", bus.rdata, 8'h5A);

`ifdef AYBUS_MASTER_CFGPORT_EN
    run(2'b11, 8'h3B, 1'b0);
    chk("cfg_code", s_code, 3'b111);
    chk("cfg_dout", s_dout, 8'hFB);
    chk("cfg_done_lat", t_done, 24);
`else
    bus.req = 1'b1; bus.cmd = 2'b11; bus.wdata = 8'h3B;
    n_err = 0; n_busy = 0; n_act = 0;
    @(negedge clk);
    bus.req = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.err) n_err++;
      if (!bus.ready) n_busy++;
      if (bus.aya8 || bus.ayd_oe || !bus.aya9_n) n_act++;
    end
    chk("cfg_err_pulses", n_err, 1);
    chk("cfg_busy", n_busy, 0);
    chk("cfg_bus_act", n_act, 0);
`endif

    bus.req = 1'b1; bus.cmd = 2'b00; bus.wdata = 8'h55;
    @(negedge clk);
    bus.req = 1'b0;
    repeat (S + 9) @(negedge clk);
    chk("rs_in_strobe", {bus.aybdir, bus.aybc2, bus.aybc1}, 3'b111);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rs_async_idle", {bus.aybdir, bus.aybc2, bus.aybc1, bus.aya8, bus.aya9_n, bus.ayd_oe},
        6'b010010);
    chk("rs_async_ready", {bus.ready, bus.done}, 2'b10);
    chk("rs_rdata", bus.rdata, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0; n_busy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) n_done++;
      if (!bus.ready) n_busy++;
    end
    chk("rs_no_done", n_done, 0);
    chk("rs_ready_after", n_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aybus_master.md
AYBUS_MASTER -- requirements
Module: aybus_master

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2, meaning address/data setup clocks before the strobe.
REQ-002 SHALL have parameter STROBE_CYC, default 20, meaning strobe width in clocks.
REQ-003 SHALL have parameter HOLD_CYC, default 2, meaning address/data hold clocks after the strobe.
REQ-004 SHALL have parameter RECOV_CYC, default 8, meaning idle clocks before the next cycle may start.
REQ-005 SHALL have ports: clk  in  1  single clock; rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: req  in  1  start request; cmd  in  2  00 wr-addr, 01 wr-data, 10 rd-data, 11 cfg-port write; wdata  in  8  write value.
REQ-007 SHALL have ports: ready  out  1  idle, accepting req; done  out  1  one-clock completion pulse; err  out  1  one-clock reject pulse; rdata  out  8  last read value.
REQ-008 SHALL have ports: aybdir, aybc2, aybc1, aya8, aya9_n  out  1 each  AY bus controls; ayd_o  out  8  bus data; ayd_oe  out  1  bus drive enable; ayd_i  in  8  bus read data.

Function
REQ-009 SHALL implement FSM IDLE -> SETUP -> STROBE -> HOLD -> RECOV -> IDLE, each non-IDLE state lasting exactly its parameter in clocks.
REQ-010 SHALL accept req only when ready=1 (state IDLE), latching cmd and wdata in that clock; req with ready=0 is ignored.
REQ-011 SHALL leave IDLE with ready=0 on the clock after acceptance and drive ready=1 again the clock after RECOV ends.
REQ-012 SHALL hold idle bus outputs in IDLE and RECOV: aybdir=0, aybc2=1, aybc1=0, aya8=0, aya9_n=1, ayd_oe=0.
REQ-013 SHALL drive aya8=1 and aya9_n=0 throughout SETUP, STROBE and HOLD; {aybdir,aybc2,aybc1} stays 010 outside STROBE.
REQ-014 SHALL drive {aybdir,aybc2,aybc1} during STROBE as: 111 for wr-addr and cfg, 110 for wr-data, 011 for rd-data.
REQ-015 SHALL drive ayd_oe=1 with ayd_o = latched value during SETUP, STROBE and HOLD for write commands, and ayd_oe=0 for rd-data.
REQ-016 SHALL drive ayd_o = {4'hF, wdata[3:0]} for cfg; wdata[7:4] is ignored.
REQ-017 SHALL drive ayd_o = wdata unmodified for wr-addr even if wdata[7:4]=F; the caller owns that aliasing.
REQ-018 SHALL sample ayd_i into rdata on the last STROBE clock of a rd-data cycle, leaving rdata unchanged by all other cycles.
REQ-019 SHALL pulse done for one clock on the first RECOV clock of every accepted cycle.
REQ-020 SHALL use one 5-bit phase counter; parameters SHALL be 1..31, with out-of-range values rejected at elaboration.
REQ-021 SHALL change all bus outputs only on clk rising edges from registers, with no combinational path from req/cmd to bus pins.

Reset
REQ-022 SHALL, while rst_n=0, asynchronously force state IDLE, the idle bus values of REQ-012, ayd_o=00, ready=1, done=0, err=0 and rdata=00.
REQ-023 SHALL abort any cycle in progress on reset, releasing the strobe and data drive immediately, with no done pulse.

Configuration
REQ-024 SHALL compile the cfg command only under macro AYBUS_MASTER_CFGPORT_EN.
REQ-025 SHALL, without AYBUS_MASTER_CFGPORT_EN, reject cmd=11: the cycle is not started, ready stays 1, err pulses one clock, and the bus stays idle.

Structure
REQ-026 SHALL take cmd encodings, the three strobe codes (111/110/011), the idle code 010 and the FSM state enum from shared package aybus_pkg.
REQ-027 SHALL place the phase counter in one sub-module aybus_timer, which loads a length, counts down and flags its last clock.

Verification
REQ-028 Bench SHALL check: wr-addr wdata=07 -> 2 clk setup with aya8=1, then 20 clk of 111 with ayd_o=07, then 2 clk hold, done 24 clk after accept, ready 32 clk after accept.
REQ-029 Bench SHALL check: rd-data with ayd_i=5A on the last strobe clock and A5 elsewhere -> rdata=5A, ayd_oe=0 throughout, strobe code 011.
REQ-030 Bench SHALL check: wr-data wdata=C3, with a second req held high during the cycle -> a single 110 strobe, the second req ignored, then the next cycle starts only after ready=1.
REQ-031 Bench SHALL check: cmd=11 wdata=3B -> ayd_o=FB under strobe 111 with the macro defined; without the macro, a single err pulse and no bus activity.
REQ-032 Bench SHALL check: rst_n low at strobe clock 10 -> same-time idle bus, ayd_oe=0, no done, and ready=1 after release.
REQ-033 Bench SHALL check: loopback into the existing bus decoder -> YM wr strobe and latched data match for a wr-addr then wr-data pair.
